halut_result_collector: RTL and testbench
=========================================

Name: halut_result_collector

Overview:
- Receive end of the halut_matmul decoder outputs: per-lane FP32 `result_o`, `valid_o` and `m_addr_o`.
- Assembles one complete output row of M results, in any arrival order, into a ping-pong (2-bank) buffer.
- Streams each completed row out in ascending m order over a valid/ready interface toward writeback/DMA.
- Collection of row n+1 proceeds while row n drains.

Parameters:
- M, 32, number of output columns per row.
- DecoderUnits, 16, decoder units per decoder_x lane.
- DecUnitsX, M / DecoderUnits, number of parallel input lanes (do not change).
- MAddrWidth, $clog2(M), column address width (do not change).
- RowCntWidth, 16, width of the drained-row counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- result_i  in  32 x DecUnitsX  FP32 result per lane
- valid_i  in  1 x DecUnitsX  lane result valid (no backpressure upstream)
- m_addr_i  in  MAddrWidth x DecUnitsX  column index per lane
- out_valid_o  out  1  output element valid
- out_ready_i  in  1  downstream accepts element
- out_data_o  out  32  FP32 element
- out_m_o  out  MAddrWidth  column index of element
- out_last_o  out  1  high with element m=M-1
- out_row_o  out  RowCntWidth  index of row being drained
- overflow_o  out  1  sticky: write dropped because target bank full
- dup_err_o  out  1  sticky: column written twice within one row
- busy_o  out  1  any bank holds partial or full data

Behaviour:
- One clock (clk_i); reset synchronous, active-low (rst_ni), sampled on rising edge.
- Reset: all outputs 0; both bitmaps cleared; both full flags 0; fill_sel=0, drain_sel=0, drain index 0, row counter 0. Data arrays are not reset. Reset mid-drain discards all buffered data.
- State per bank b: data[b][M] (32 b), bitmap[b] (M b), full[b].
- Write, lane x with valid_i[x]:
  - If full[fill_sel]=0: data[fill_sel][m_addr_i[x]] <= result_i[x] and the bitmap bit is set, at the edge.
  - If full[fill_sel]=1: write dropped, overflow_o set (sticky until reset).
- Same m on two lanes in one cycle: highest lane index wins; dup_err_o set.
- Write to a column whose bitmap bit is already set: data overwritten; dup_err_o set.
- Completion: if (bitmap[fill_sel] | this-cycle write mask) is all ones, then at that edge full[fill_sel]<=1 and fill_sel toggles. Writes in the next cycle target the other bank.
- Drain FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN when full[drain_sel]=1; drain index=0.
  - DRAIN: out_valid_o=1; out_data_o=data[drain_sel][idx]; out_m_o=idx; out_last_o=(idx==M-1).
  - Handshake on out_valid_o & out_ready_i advances idx.
  - On last handshake: bitmap[drain_sel] and full[drain_sel] cleared; drain_sel toggles; out_row_o increments (wraps); FSM goes to IDLE.
  - If the other bank is already full, IDLE is transient: DRAIN re-entered next cycle.
  - Without ready, out_* stay stable.
- Latency: last write of a row at edge t -> out_valid_o high in cycle t+1 with out_m_o=0. Throughput 1 element/cycle while out_ready_i=1.
- Bank release and completion on the same edge: the freed bank is available to the fill side from the next cycle.
- busy_o = |bitmap[0] | |bitmap[1] | full[0] | full[1].

Test Plan:
- Ordered fill: lane0 m=0..15 and lane1 m=16..31, one per cycle, result=0x3F800000+m, out_ready_i=1 -> out_valid_o rises the cycle after the 16th write. Then 32 beats: m=0..31, data=0x3F800000+m, out_last_o only at m=31, out_row_o=0, then 1 after the row.
- Reverse-order fill, out_ready_i random 50% -> identical stream order; data/m stable while stalled; no loss; overflow_o=0.
- Ping-pong: write row1 (data 0xA0000000+m) while row0 drains -> row0 fully, then row1 fully, back-to-back; overflow_o=0.
- Overflow: out_ready_i=0, write three complete rows -> third row's writes all dropped, overflow_o=1. Release ready -> exactly rows 0 and 1 output.
- Duplicate: m=5 written 0x11111111 then 0x22222222 in one row -> dup_err_o=1, output m=5 is 0x22222222. Repeat with both lanes m=7 in the same cycle -> lane1 value output.
- Reset mid-drain at beat 10 -> next cycle all outputs 0, busy_o=0. A fresh full row then drains from m=0 with out_row_o=0.

Source files
------------

// File: rtl/halut_result_collector.sv
// rtl/halut_result_collector.sv - ping-pong row collector for halut_matmul decoder results
// Two banks alternate: one assembles a row in any column order while the other streams out in m order.
module halut_result_collector #(
  parameter int M           = 32,
  parameter int DecoderUnits = 16,
  parameter int DecUnitsX   = M / DecoderUnits,
  parameter int MAddrWidth  = $clog2(M),
  parameter int RowCntWidth = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [32*DecUnitsX-1:0]       result_i,
  input  logic [DecUnitsX-1:0]          valid_i,
  input  logic [MAddrWidth*DecUnitsX-1:0] m_addr_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [31:0]                   out_data_o,
  output logic [MAddrWidth-1:0]         out_m_o,
  output logic                          out_last_o,
  output logic [RowCntWidth-1:0]        out_row_o,
  output logic                          overflow_o,
  output logic                          dup_err_o,
  output logic                          busy_o
);

  typedef enum logic {S_IDLE, S_DRAIN} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [31:0]            r_data [2][M];
  logic [M-1:0]           r_bitmap [2];
  logic [1:0]             r_full;
  logic                   r_fill_sel;
  logic                   r_drain_sel;
  logic [MAddrWidth-1:0]  r_idx;
  logic [RowCntWidth-1:0] r_row;
  logic                   r_overflow;
  logic                   r_dup;

  logic [MAddrWidth-1:0]  w_addr [DecUnitsX];
  logic [M-1:0]           w_wmask;
  logic                   w_lane_clash;
  logic                   w_any_valid;
  logic                   w_accept;
  logic                   w_rewrite;
  logic                   w_complete;
  logic                   w_fire;
  logic                   w_last_fire;

  // Column mask of this cycle's writes; a repeated column across lanes is a clash.
  always_comb begin
    w_wmask      = '0;
    w_lane_clash = 1'b0;
    for (int x = 0; x < DecUnitsX; x++) begin
      w_addr[x] = m_addr_i[MAddrWidth*x +: MAddrWidth];
      if (valid_i[x]) begin
        if (w_wmask[w_addr[x]]) w_lane_clash = 1'b1;
        w_wmask[w_addr[x]] = 1'b1;
      end
    end
  end

  assign w_any_valid = |valid_i;
  assign w_accept    = w_any_valid & ~r_full[r_fill_sel];
  assign w_rewrite   = |(w_wmask & r_bitmap[r_fill_sel]);
  assign w_complete  = w_accept & (&(r_bitmap[r_fill_sel] | w_wmask));
  assign w_fire      = (r_state == S_DRAIN) & out_ready_i;
  assign w_last_fire = w_fire & (r_idx == MAddrWidth'(M - 1));

  // Completing the drain bank itself lets DRAIN start the very next cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_drain_sel] || (w_complete && (r_fill_sel == r_drain_sel)))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Later lanes override earlier ones on the same column.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int x = 0; x < DecUnitsX; x++) begin
        if (valid_i[x]) r_data[r_fill_sel][w_addr[x]] <= result_i[32*x +: 32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_bitmap[0] <= '0;
      r_bitmap[1] <= '0;
      r_full      <= '0;
      r_fill_sel  <= 1'b0;
      r_drain_sel <= 1'b0;
      r_idx       <= '0;
      r_row       <= '0;
      r_overflow  <= 1'b0;
      r_dup       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_bitmap[r_fill_sel] <= r_bitmap[r_fill_sel] | w_wmask;
      if (w_complete) begin
        r_full[r_fill_sel] <= 1'b1;
        r_fill_sel         <= ~r_fill_sel;
      end
      if (w_last_fire) begin
        r_bitmap[r_drain_sel] <= '0;
        r_full[r_drain_sel]   <= 1'b0;
        r_drain_sel           <= ~r_drain_sel;
        r_row                 <= r_row + 1'b1;
        r_idx                 <= '0;
      end else if (w_fire) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_any_valid && r_full[r_fill_sel]) r_overflow <= 1'b1;
      if (w_accept && (w_lane_clash || w_rewrite)) r_dup <= 1'b1;
    end
  end

  assign out_valid_o = (r_state == S_DRAIN);
  assign out_data_o  = out_valid_o ? r_data[r_drain_sel][r_idx] : 32'h0;
  assign out_m_o     = r_idx;
  assign out_last_o  = out_valid_o & (r_idx == MAddrWidth'(M - 1));
  assign out_row_o   = r_row;
  assign overflow_o  = r_overflow;
  assign dup_err_o   = r_dup;
  assign busy_o      = (|r_bitmap[0]) | (|r_bitmap[1]) | (|r_full);

endmodule

// File: tb/tb_halut_result_collector.sv
// tb/tb_halut_result_collector.sv - bench for halut_result_collector
// Row-level reference model: completed rows queue up, at most two held, drained in m order.
module tb_halut_result_collector;

  localparam int M  = 32;
  localparam int NX = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [32*NX-1:0]  result_i;
  logic [NX-1:0]     valid_i;
  logic [AW*NX-1:0]  m_addr_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_data_o;
  logic [AW-1:0]     out_m_o;
  logic              out_last_o;
  logic [15:0]       out_row_o;
  logic              overflow_o;
  logic              dup_err_o;
  logic              busy_o;

  halut_result_collector dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .result_i    (result_i),
    .valid_i     (valid_i),
    .m_addr_i    (m_addr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_m_o     (out_m_o),
    .out_last_o  (out_last_o),
    .out_row_o   (out_row_o),
    .overflow_o  (overflow_o),
    .dup_err_o   (dup_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  logic [31:0] part_data [M];
  bit [M-1:0]  part_map;
  int          full_rows;
  bit          exp_ovf;
  bit          exp_dup;
  logic [15:0] exp_row;
  int          beat_cnt;
  logic [31:0] exp_q [$];
  int          ord_q [$];
  bit          prev_stall;
  logic [31:0] prev_data;
  logic [AW-1:0] prev_m;
  logic [31:0] exp_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    part_map  = '0;
    full_rows = 0;
    exp_ovf   = 1'b0;
    exp_dup   = 1'b0;
    exp_row   = '0;
    beat_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic mdl_lane(input logic [AW-1:0] m, input logic [31:0] d);
    if (part_map[m]) exp_dup = 1'b1;
    part_data[m] = d;
    part_map[m]  = 1'b1;
  endtask

  task automatic mdl_cycle(input logic v0, input logic [AW-1:0] m0, input logic [31:0] d0,
                           input logic v1, input logic [AW-1:0] m1, input logic [31:0] d1);
    if (!(v0 || v1)) return;
    if (full_rows == 2) begin
      exp_ovf = 1'b1;
      return;
    end
    if (v0) mdl_lane(m0, d0);
    if (v1) mdl_lane(m1, d1);
    if (&part_map) begin
      for (int m = 0; m < M; m++) exp_q.push_back(part_data[m]);
      full_rows++;
      part_map = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready_i = 1'b0;
      1:       out_ready_i = 1'b1;
      default: out_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] m0, input logic [31:0] d0,
                       input logic v1, input logic [AW-1:0] m1, input logic [31:0] d1);
    valid_i  = {v1, v0};
    m_addr_i = {m1, m0};
    result_i = {d1, d0};
    mdl_cycle(v0, m0, d0, v1, m1, d1);
    step();
    valid_i = '0;
  endtask

  // mode 0: ascending pairs, 1: descending pairs, 2: random permutation
  task automatic make_ord(input int mode);
    ord_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (mode == 1) begin
        ord_q.push_back(15 - i);
        ord_q.push_back(31 - i);
      end else begin
        ord_q.push_back(i);
        ord_q.push_back(16 + i);
      end
    end
    if (mode == 2) begin
      for (int i = M - 1; i > 0; i--) begin
        int j;
        int t;
        j = int'($urandom_range(0, i));
        t = ord_q[i];
        ord_q[i] = ord_q[j];
        ord_q[j] = t;
      end
    end
  endtask

  task automatic write_list(input logic [31:0] base);
    for (int i = 0; i < ord_q.size(); i += 2) begin
      if (i + 1 < ord_q.size())
        drive(1'b1, AW'(ord_q[i]), base + 32'(ord_q[i]), 1'b1, AW'(ord_q[i+1]), base + 32'(ord_q[i+1]));
      else
        drive(1'b1, AW'(ord_q[i]), base + 32'(ord_q[i]), 1'b0, '0, '0);
    end
  endtask

  task automatic write_except(input int skip, input logic [31:0] base);
    ord_q.delete();
    for (int m = 0; m < M; m++) if (m != skip) ord_q.push_back(m);
    write_list(base);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    step();
    chk({tag, "_ovf"}, 32'(overflow_o), 32'(exp_ovf));
    chk({tag, "_dup"}, 32'(dup_err_o), 32'(exp_dup));
    chk({tag, "_busy"}, 32'(busy_o), 32'((part_map != '0) || (full_rows != 0)));
    chk({tag, "_row"}, 32'(out_row_o), 32'(exp_row));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_data"}, out_data_o, 32'd0);
    chk({tag, "_m"}, 32'(out_m_o), 32'd0);
    chk({tag, "_last"}, 32'(out_last_o), 32'd0);
    chk({tag, "_row"}, 32'(out_row_o), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    chk({tag, "_dup"}, 32'(dup_err_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  // Output monitor: every accepted beat is scored against the model; stalled beats must hold.
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_data", out_data_o, prev_data);
        chk("stall_m", 32'(out_m_o), 32'(prev_m));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(out_valid_o), 32'd0);
        end else begin
          exp_d = exp_q.pop_front();
          chk("beat_data", out_data_o, exp_d);
          chk("beat_m", 32'(out_m_o), 32'(beat_cnt));
          chk("beat_last", 32'(out_last_o), 32'(beat_cnt == M - 1));
          chk("beat_row", 32'(out_row_o), 32'(exp_row));
          if (beat_cnt == M - 1) begin
            beat_cnt = 0;
            exp_row++;
            full_rows--;
          end else begin
            beat_cnt++;
          end
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_m     = out_m_o;
    end
  end

  initial begin
    int n;
    rst_ni      = 1'b0;
    valid_i     = '0;
    m_addr_i    = '0;
    result_i    = '0;
    out_ready_i = 1'b0;
    mdl_reset();
    step();
    step();
    chk_zero("reset");
    rst_ni = 1'b1;
    step();

    // Ordered fill with always-ready sink and first-beat latency
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("pre_valid", 32'(out_valid_o), 32'd0);
      drive(1'b1, AW'(i), 32'h3F80_0000 + 32'(i), 1'b1, AW'(16 + i), 32'h3F80_0000 + 32'(16 + i));
    end
    chk("lat_valid", 32'(out_valid_o), 32'd1);
    chk("lat_m", 32'(out_m_o), 32'd0);
    chk("lat_data", out_data_o, 32'h3F80_0000);
    wait_drain("ordered");

    // Reverse fill against a randomly stalling sink
    rdy_mode = 2;
    make_ord(1);
    write_list(32'hC000_0000);
    wait_drain("reverse");

    // Ping-pong: second row collected while the first drains
    rdy_mode = 1;
    make_ord(2);
    write_list(32'h4000_0000);
    make_ord(0);
    write_list(32'hA000_0000);
    wait_drain("pingpong");

    // Overflow: three rows with the sink blocked, third row must be dropped
    rdy_mode = 0;
    step();
    make_ord(0);
    write_list(32'h5000_0000);
    write_list(32'h6000_0000);
    make_ord(2);
    write_list(32'h7000_0000);
    chk("ovf_flag", 32'(overflow_o), 32'(exp_ovf));
    chk("ovf_queued", 32'(exp_q.size()), 32'(2 * M));
    rdy_mode = 1;
    wait_drain("overflow");

    // Duplicates: rewrite across cycles, then clash across lanes
    drive(1'b1, AW'(5), 32'h1111_1111, 1'b0, '0, '0);
    chk("dup_first", 32'(dup_err_o), 32'd0);
    drive(1'b1, AW'(5), 32'h2222_2222, 1'b0, '0, '0);
    chk("dup_rewrite", 32'(dup_err_o), 32'd1);
    write_except(5, 32'h8000_0000);
    drive(1'b1, AW'(7), 32'h3333_3333, 1'b1, AW'(7), 32'h4444_4444);
    write_except(7, 32'h8100_0000);
    wait_drain("dup");

    // Reset in the middle of a drain
    make_ord(0);
    write_list(32'h9000_0000);
    n = 0;
    while (beat_cnt != 10 && n < 100) begin
      step();
      n++;
    end
    chk("beat10_reached", 32'(beat_cnt), 32'd10);
    rst_ni      = 1'b0;
    rdy_mode    = 0;
    out_ready_i = 1'b0;
    mdl_reset();
    step();
    chk_zero("midreset");
    rst_ni   = 1'b1;
    rdy_mode = 1;
    make_ord(2);
    write_list(32'hB000_0000);
    wait_drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
